// File: rtl/serial_rx_mc_pkg.sv
// Shared types, widths and clamp helpers for the multi-lane serial receiver.
// Parity support is enabled with the SERIAL_RX_MC_PARITY_EN macro.
package serial_rx_mc_pkg;

    localparam int unsigned CNT_W   = 32;
    localparam int unsigned NBITS_W = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_SHIFT = 3'd2,
        S_PAR   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Tick counts of zero would never match; treat them as one tick.
    function automatic logic [CNT_W-1:0] clamp_min1(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

    function automatic logic [NBITS_W-1:0] clamp_nbits(input logic [NBITS_W-1:0] nb,
                                                      input logic [NBITS_W-1:0] max_nb);
        if (nb == '0)
            return NBITS_W'(1);
        else if (nb > max_nb)
            return max_nb;
        else
            return nb;
    endfunction

endpackage

// File: rtl/serial_rx_lane.sv
// One receive lane: working shift word written by bit index, plus an optional
// even-parity accumulator (SERIAL_RX_MC_PARITY_EN).
module serial_rx_lane
    import serial_rx_mc_pkg::*;
#(
    parameter int unsigned P_W = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clr,
    input  logic               i_smp,
    input  logic [NBITS_W-1:0] i_idx,
    input  logic               i_bit,
`ifdef SERIAL_RX_MC_PARITY_EN
    input  logic               i_par_smp,
    output logic               o_par,
`endif
    output logic [P_W-1:0]     o_word
);

    logic [P_W-1:0] r_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word <= '0;
        end else if (i_clr) begin
            r_word <= '0;
        end else if (i_smp) begin
            for (int unsigned b = 0; b < P_W; b++) begin
                if (i_idx == NBITS_W'(b))
                    r_word[b] <= i_bit;
            end
        end
    end

    assign o_word = r_word;

`ifdef SERIAL_RX_MC_PARITY_EN
    // Running XOR over data bits and the trailing parity bit; 1 means error.
    logic r_par;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_par <= 1'b0;
        else if (i_clr)
            r_par <= 1'b0;
        else if (i_smp || i_par_smp)
            r_par <= r_par ^ i_bit;
    end

    assign o_par = r_par;
`endif

endmodule

// File: rtl/serial_rx_mc.sv
// Multi-lane cnt-referenced serial receiver with double-buffered output.
// Optional trailing even-parity bit per lane: define SERIAL_RX_MC_PARITY_EN.
module serial_rx_mc
    import serial_rx_mc_pkg::*;
#(
    parameter int unsigned P_NCH = 4,
    parameter int unsigned P_W   = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start,
    input  logic                   i_abort,
    input  logic                   i_lsb_first,
    input  logic [P_NCH-1:0]       i_a,
    input  logic [NBITS_W-1:0]     i_nbits,
    input  logic [CNT_W-1:0]       i_n0,
    input  logic [CNT_W-1:0]       i_n1,
    input  logic [CNT_W-1:0]       i_cnt,
    output logic [P_NCH*P_W-1:0]   o_data,
    output logic                   o_valid,
    output logic                   o_busy,
    output logic [P_NCH-1:0]       o_perr
);

    state_t               r_state;
    logic [CNT_W-1:0]     r_tgt;
    logic [CNT_W-1:0]     r_n1;
    logic [NBITS_W-1:0]   r_nb;
    logic [NBITS_W-1:0]   r_bitcnt;
    logic                 r_lsb;
    logic [P_NCH*P_W-1:0] r_data;
    logic                 r_valid;
    logic                 r_busy;

    logic                 w_hit;
    logic                 w_clr;
    logic                 w_smp;
    logic                 w_last;
    logic [NBITS_W-1:0]   w_idx;
    logic [P_NCH*P_W-1:0] w_word;

    assign w_hit  = (i_cnt == r_tgt);
    assign w_clr  = (r_state == S_IDLE) && i_start && !i_abort;
    assign w_smp  = ((r_state == S_WAIT) || (r_state == S_SHIFT)) && w_hit && !i_abort;
    assign w_last = (r_bitcnt == (r_nb - NBITS_W'(1)));
    // MSB-first frames fill from the top of the clamped width so the word ends right-justified.
    assign w_idx  = r_lsb ? r_bitcnt : (r_nb - NBITS_W'(1) - r_bitcnt);

`ifdef SERIAL_RX_MC_PARITY_EN
    logic             w_par_smp;
    logic [P_NCH-1:0] w_par;
    logic [P_NCH-1:0] r_perr;

    assign w_par_smp = (r_state == S_PAR) && w_hit && !i_abort;
    assign o_perr    = r_perr;
`else
    assign o_perr    = '0;
`endif

    for (genvar k = 0; k < P_NCH; k++) begin : g_lane
        serial_rx_lane #(
            .P_W (P_W)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .i_clr     (w_clr),
            .i_smp     (w_smp),
            .i_idx     (w_idx),
            .i_bit     (i_a[k]),
`ifdef SERIAL_RX_MC_PARITY_EN
            .i_par_smp (w_par_smp),
            .o_par     (w_par[k]),
`endif
            .o_word    (w_word[k*P_W +: P_W])
        );
    end

    // Frame sequencer; abort from any active state takes priority over everything else.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_tgt    <= '0;
            r_n1     <= '0;
            r_nb     <= '0;
            r_bitcnt <= '0;
            r_lsb    <= 1'b0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
`ifdef SERIAL_RX_MC_PARITY_EN
            r_perr   <= '0;
`endif
        end else begin
            r_valid <= 1'b0;
            if ((r_state != S_IDLE) && i_abort) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_start && !i_abort) begin
                            r_state  <= S_WAIT;
                            r_tgt    <= i_cnt + clamp_min1(i_n0);
                            r_n1     <= clamp_min1(i_n1);
                            r_nb     <= clamp_nbits(i_nbits, NBITS_W'(P_W));
                            r_lsb    <= i_lsb_first;
                            r_bitcnt <= '0;
                            r_busy   <= 1'b1;
                        end
                    end
                    S_WAIT, S_SHIFT: begin
                        if (w_hit) begin
                            r_bitcnt <= r_bitcnt + NBITS_W'(1);
                            r_tgt    <= r_tgt + r_n1;
`ifdef SERIAL_RX_MC_PARITY_EN
                            r_state  <= w_last ? S_PAR : S_SHIFT;
`else
                            r_state  <= w_last ? S_DONE : S_SHIFT;
`endif
                        end
                    end
`ifdef SERIAL_RX_MC_PARITY_EN
                    S_PAR: begin
                        if (w_hit)
                            r_state <= S_DONE;
                    end
`endif
                    S_DONE: begin
                        r_data  <= w_word;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b0;
`ifdef SERIAL_RX_MC_PARITY_EN
                        r_perr  <= w_par;
`endif
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_busy  = r_busy;

endmodule

// File: tb/tb_serial_rx_mc.sv
// Scoreboard bench for serial_rx_mc: the driver pushes expected words, a monitor checks each valid.
module tb_serial_rx_mc;

    localparam int unsigned NCH = 4;
    localparam int unsigned W   = 64;
    localparam int unsigned DW  = NCH * W;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          lsb   = 1'b0;
    logic [NCH-1:0] a    = '0;
    logic [7:0]    nbits = '0;
    logic [31:0]   n0    = '0;
    logic [31:0]   n1    = '0;
    logic [31:0]   cnt   = '0;
    logic [DW-1:0] data;
    logic          valid;
    logic          busy;
    logic [NCH-1:0] perr;

    serial_rx_mc #(.P_NCH(NCH), .P_W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (start),
        .i_abort     (abort),
        .i_lsb_first (lsb),
        .i_a         (a),
        .i_nbits     (nbits),
        .i_n0        (n0),
        .i_n1        (n1),
        .i_cnt       (cnt),
        .o_data      (data),
        .o_valid     (valid),
        .o_busy      (busy),
        .o_perr      (perr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0]  data;
        logic [NCH-1:0] perr;
        logic [31:0]    vcnt;
    } exp_t;

    exp_t          sb[$];
    int            n_chk  = 0;
    int            n_pass = 0;
    logic [DW-1:0] last_data = '0;

    // Descriptor of the frame currently being transmitted by the bench.
    logic          f_on = 1'b0;
    logic [31:0]   f_s, f_n0, f_n1;
    int            f_nb;
    logic          f_lsb;
    logic [63:0]   f_w [NCH];
    logic [NCH-1:0] f_par;

`ifdef SERIAL_RX_MC_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
    endtask

    function automatic logic [63:0] mask(input logic [63:0] w, input int nb);
        return (nb >= 64) ? w : (w & ((64'd1 << nb) - 64'd1));
    endfunction

    // Lane values for the current cnt: frame bits on sample ticks, noise elsewhere.
    function automatic logic [NCH-1:0] lane_bits(input logic [31:0] c);
        logic [31:0]    d;
        logic [31:0]    j;
        logic [NCH-1:0] r;
        int             pos;
        r = NCH'($urandom);
        if (!f_on)
            return r;
        d = c - f_s - f_n0;
        if ((d % f_n1) != 0)
            return r;
        j = d / f_n1;
        if (j < 32'(f_nb)) begin
            pos = f_lsb ? int'(j) : (f_nb - 1 - int'(j));
            for (int k = 0; k < int'(NCH); k++)
                r[k] = f_w[k][6'(pos)];
        end else if ((PAR_BITS != 0) && (j == 32'(f_nb))) begin
            r = f_par;
        end
        return r;
    endfunction

    task automatic step();
        @(negedge clk);
        cnt = cnt + 32'd1;
        a   = lane_bits(cnt);
    endtask

    task automatic launch(input logic [31:0] s, input logic [7:0] nb,
                          input logic [31:0] t0, input logic [31:0] t1, input logic ls,
                          input logic [63:0] w0, input logic [63:0] w1,
                          input logic [63:0] w2, input logic [63:0] w3,
                          input logic [NCH-1:0] bad_par, input bit expect_done);
        int          nbc;
        logic [31:0] n0c, n1c;
        exp_t        e;
        nbc   = (nb == 0) ? 1 : ((nb > 8'd64) ? 64 : int'(nb));
        n0c   = (t0 == 0) ? 32'd1 : t0;
        n1c   = (t1 == 0) ? 32'd1 : t1;
        f_s   = s;
        f_n0  = n0c;
        f_n1  = n1c;
        f_nb  = nbc;
        f_lsb = ls;
        f_w[0] = w0; f_w[1] = w1; f_w[2] = w2; f_w[3] = w3;
        for (int k = 0; k < int'(NCH); k++)
            f_par[k] = (^mask(f_w[k], nbc)) ^ bad_par[k];
        @(negedge clk);
        cnt   = s;
        start = 1'b1;
        nbits = nb;
        n0    = t0;
        n1    = t1;
        lsb   = ls;
        f_on  = 1'b1;
        a     = lane_bits(cnt);
        if (expect_done) begin
            e.data = {mask(w3, nbc), mask(w2, nbc), mask(w1, nbc), mask(w0, nbc)};
            e.perr = (PAR_BITS != 0) ? bad_par : '0;
            e.vcnt = s + n0c + n1c * 32'(nbc - 1 + PAR_BITS) + 32'd1;
            sb.push_back(e);
            last_data = e.data;
        end
        step();
        start = 1'b0;
        nbits = 8'($urandom);
        n0    = 32'($urandom_range(1, 9));
        n1    = 32'($urandom_range(1, 9));
        lsb   = ~ls;
        chk("busy_rise", DW'(busy), DW'(1'b1));
    endtask

    task automatic wait_done(input string nm);
        int c;
        c = 0;
        while (busy && c < 5000) begin
            step();
            c++;
        end
        chk({nm, "_done_in_time"}, DW'(c < 5000), DW'(1'b1));
        f_on = 1'b0;
        step();
        step();
    endtask

    // Monitor: every valid must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_valid", DW'(valid), DW'(1'b0));
                end else begin
                    e = sb.pop_front();
                    chk("data", data, e.data);
                    chk("perr", DW'(perr), DW'(e.perr));
                    chk("valid_cnt", DW'(cnt), DW'(e.vcnt));
                end
            end
        end
    end

    initial begin
        int g;
        step();
        step();
        chk("rst_data",  data,        '0);
        chk("rst_valid", DW'(valid),  '0);
        chk("rst_busy",  DW'(busy),   '0);
        chk("rst_perr",  DW'(perr),   '0);
        rst = 1'b0;
        step();

        launch(32'd100, 8'd8, 32'd3, 32'd2, 1'b0,
               64'hA5, 64'h3C, 64'hFF, 64'h00, 4'b0000, 1'b1);
        wait_done("msb_basic");

        launch(32'd500, 8'd8, 32'd1, 32'd1, 1'b1,
               64'h12, 64'h81, 64'h7E, 64'h55, 4'b0000, 1'b1);
        wait_done("lsb_first");

        launch(32'd700, 8'd0, 32'd2, 32'd3, 1'b0,
               64'h3, 64'h2, 64'h5, 64'h7, 4'b0000, 1'b1);
        wait_done("nbits_zero");

        launch(32'd900, 8'd200, 32'd5, 32'd1, 1'b1,
               64'h0123456789ABCDEF, 64'hFEDCBA9876543210,
               64'hDEADBEEFCAFEF00D, 64'h8000000000000001, 4'b0000, 1'b1);
        wait_done("nbits_clamp");

        launch(32'd2000, 8'd6, 32'd0, 32'd0, 1'b0,
               64'h2D, 64'h15, 64'h3F, 64'h2A, 4'b0000, 1'b1);
        wait_done("tick_clamp");

        launch(32'hFFFF_FFFE, 8'd8, 32'd2, 32'd1, 1'b0,
               64'hC3, 64'h5A, 64'h01, 64'h80, 4'b0000, 1'b1);
        wait_done("cnt_wrap");

        // Abort after three samples (3002, 3004, 3006).
        launch(32'd3000, 8'd8, 32'd2, 32'd2, 1'b0,
               64'hF0, 64'h0F, 64'hAA, 64'h55, 4'b0000, 1'b0);
        g = 0;
        while (cnt != 32'd3007 && g < 50) begin
            step();
            g++;
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy",  DW'(busy),  '0);
        chk("abort_data",  data,       last_data);
        chk("abort_valid", DW'(valid), '0);
        f_on = 1'b0;
        for (int i = 0; i < 20; i++)
            step();
        chk("abort_busy_stays", DW'(busy), '0);

        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("abort_beats_start", DW'(busy), '0);
        step();

        // A second start mid-frame must not disturb the running frame.
        launch(32'd4000, 8'd8, 32'd2, 32'd3, 1'b0,
               64'h69, 64'h96, 64'hF0, 64'h0F, 4'b0000, 1'b1);
        for (int i = 0; i < 5; i++)
            step();
        start = 1'b1;
        nbits = 8'd3;
        n0    = 32'd1;
        n1    = 32'd1;
        lsb   = 1'b1;
        step();
        start = 1'b0;
        wait_done("start_while_busy");

        launch(32'd5000, 8'd8, 32'd2, 32'd2, 1'b0,
               64'h11, 64'h3C, 64'h07, 64'hFE, 4'b0100, 1'b1);
        wait_done("parity_bad_lane2");

        launch(32'd6000, 8'd8, 32'd1, 32'd2, 1'b1,
               64'h11, 64'h3C, 64'h07, 64'hFE, 4'b0000, 1'b1);
        wait_done("parity_good");

        for (int i = 0; i < 10; i++)
            step();
        chk("scoreboard_empty", DW'(sb.size()), '0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/serial_rx_mc.md
# serial_rx_mc

Multi-channel, `cnt`-driven serial receiver. It samples `P_NCH` data lanes in lockstep against a shared free-running counter. Frames are armed by an explicit `start` and support configurable bit order, with a clamped bit count of up to `P_W`. Completed words are presented in a double-buffered output register with a one-cycle `valid` strobe. It sits beside the serial transmitters in the slow-control path and deserialises multi-lane readback from front-end chips.

## Interface
- `P_NCH`, 4: number of parallel data lanes.
- `P_W`, 64: maximum bits per lane; must be ≤ 255.
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  arms one frame; accepted in IDLE only.
- `abort`  in  1  cancels the frame in progress.
- `lsb_first`  in  1  0 = MSB first, 1 = LSB first; latched at start.
- `a`  in  `P_NCH`  serial data, one bit per lane.
- `nbits`  in  8  data bits per frame; latched at start.
- `n0`  in  32  `cnt` ticks from start to the first sample; latched at start.
- `n1`  in  32  `cnt` ticks between samples; latched at start.
- `cnt`  in  32  shared timebase; all sampling is referenced to it.
- `data`  out  `P_NCH*P_W`  lane k occupies `[k*P_W +: P_W]`; right-justified, upper bits 0.
- `valid`  out  1  one-cycle strobe when `data` updates.
- `busy`  out  1  high while a frame is in progress.
- `perr`  out  `P_NCH`  per-lane parity error; 0 when the macro is absent.

## Operation
- **Reset.** Forces IDLE and clears `data`, `valid`, `busy`, `perr`, all working registers and the bit counter.
- **Clamping at start.**
  - `i_n0 = max(n0,1)`, `i_n1 = max(n1,1)`.
  - `i_nb = nbits==0 ? 1 : min(nbits,P_W)`.
  - Working registers are cleared.
- **FSM states:** IDLE, WAIT, SHIFT, PAR (macro only), DONE.
- **IDLE.** `start & ~abort` moves to WAIT with `tgt = cnt + i_n0`.
- **WAIT.** When `cnt==tgt`, take the first sample exactly as in SHIFT, then go to SHIFT.
- **SHIFT.** When `cnt==tgt`:
  - Write `a[k]` into lane k's working bit `idx`. `idx = bitcnt` if LSB first, else `i_nb-1-bitcnt`.
  - Set `bitcnt++` and `tgt += i_n1`.
  - After the sample with `bitcnt==i_nb-1`, go to PAR if the macro is present, else DONE.
- **PAR.** When `cnt==tgt`, sample the parity bit per lane, then go to DONE.
- **DONE.** One cycle:
  - `data <= working`, `valid <= 1`, `busy <= 0`, `perr` updated.
  - Return to IDLE.
- **Counter arithmetic.** All `cnt`/`tgt` arithmetic is 32-bit modulo with equality compare, so wrap-around is transparent. If `cnt` skips `tgt`, the FSM waits until `cnt` wraps back to `tgt`; `abort` is the recovery path.
- **abort.** From any non-IDLE state, returns to IDLE next edge. No `valid`, `data` unchanged, `perr` unchanged.
- **Simultaneous events.**
  - `abort` wins over `start`.
  - `start` while busy is ignored.
  - Input changes after start do not affect the current frame.

## Timing
- `busy` rises on the edge that accepts `start`.
- The first sample is taken on the first edge where `cnt == cnt_at_start + i_n0`. Subsequent samples follow every `i_n1` ticks.
- `data`, `valid` and `perr` update one clock after the edge that takes the last sample (data or parity). `busy` falls on that same edge.
- Minimum gap: a new `start` is accepted the cycle after `valid`.

## Configuration
- Macro: `SERIAL_RX_MC_PARITY_EN`.
- **Defined:**
  - One extra bit per lane follows the data bits, `i_n1` after the last data bit.
  - Even parity: `perr[k] = XOR(i_nb data bits, parity bit)`.
- **Undefined:** no PAR state, no extra sample, `perr` tied to 0.

## Structure
- **Package `serial_rx_mc_pkg`:** FSM state encoding, `CNT_W=32`, `NBITS_W=8`, and the clamp helper function.
- **Sub-module `serial_rx_lane`:** per-lane working register plus parity accumulator, instantiated `P_NCH` times. It takes a sample enable, `idx` and a clear input. The top level owns the FSM, `tgt` and `bitcnt`.

## Test plan
- **MSB first, basic frame.**
  - Stimulus: `P_NCH`=4, `nbits`=8, `n0`=3, `n1`=2, `lsb_first`=0, start at `cnt`=100; lanes carry 0xA5, 0x3C, 0xFF, 0x00.
  - Response: samples at `cnt` 103, 105 … 117; `valid` one cycle after the 117 sample; lanes read back exactly as sent.
- **LSB first.** Lane 0 sends 0x12 LSB first (0x48 when read MSB first) -> lane 0 reads 0x12.
- **Clamping.**
  - `nbits`=0 -> a 1-bit frame.
  - `nbits`=200 -> 64 bits sampled.
  - `n0`=`n1`=0 -> samples on consecutive `cnt` ticks.
- **Counter wrap.** Start at `cnt`=0xFFFFFFFE, `n0`=2, `n1`=1 -> first sample at `cnt`=0x00000000 and the frame completes correctly.
- **Abort and start-while-busy.**
  - `abort` after 3 bits -> no `valid`, prior `data` retained, `busy`=0 next cycle.
  - `start` during a frame -> ignored.
- **Parity (macro defined).** Lane 2 sends 0x07 with parity bit 0 -> `perr`=4'b0100; correct parity on all lanes -> `perr`=0.
